// File: rtl/pipeline_flow_pkg.sv
// Shared sizing helpers and parameter legality rules for the pipeline flow adapter.
package pipeline_flow_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    // Credit and occupancy counters must represent 0..depth inclusive.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit params_legal(input int width, input int latency, input int depth);
        return (width >= 1) && (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX) && (depth >= 1);
    endfunction

endpackage

// File: rtl/flow_fifo.sv
// Synchronous circular-buffer FIFO; head is the registered storage at the read pointer.
module flow_fifo
    import pipeline_flow_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = cred_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_pop = pop & ~empty;
    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign head   = mem[rd_ptr];

    // NOTE: storage is reset so that out_data reads as zero after reset; this keeps
    // the RAM in flops, which is acceptable at this depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pipeline_flow_adapter.sv
// Valid/ready shell around a fixed-latency, non-stalling pipeline: credit-gated issue,
// valid shift register tracking in-flight items, and a result FIFO for backpressure.
module pipeline_flow_adapter
    import pipeline_flow_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pipe_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CRED_W = cred_width(DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

    if (!params_legal(WIDTH, LATENCY, DEPTH)) begin : g_bad_params
        $error("pipeline_flow_adapter: WIDTH>=1, LATENCY in 1..8 and DEPTH>=1 required");
    end

    logic [CRED_W-1:0]  cred;
    logic [CRED_W-1:0]  cred_next;
    logic [LATENCY-1:0] vsr;
    logic [CRED_W-1:0]  fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               pop;
    logic               capture;

    assign in_ready  = (cred != '0);
    assign accept    = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign capture   = vsr[LATENCY-1];

    // NOTE: the default assignment first keeps this block purely combinational.
    always_comb begin
        cred_next = cred;
        if (accept && !pop) begin
            cred_next = cred - CRED_ONE;
        end else if (!accept && pop) begin
            cred_next = cred + CRED_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred <= CRED_MAX;
        end else begin
            cred <= cred_next;
        end
    end

    // The top vsr bit lines up with the cycle in which pipe_result belongs to an issued item.
    if (LATENCY == 1) begin : g_vsr_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vsr <= '0;
            end else begin
                vsr <= accept;
            end
        end
    end else begin : g_vsr_shift
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vsr <= '0;
            end else begin
                vsr <= {vsr[LATENCY-2:0], accept};
            end
        end
    end

    flow_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .wdata (pipe_result),
        .head  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) capture |-> !fifo_full);
    a_cred_no_overflow: assert property (@(posedge clk) disable iff (rst) pop |-> (cred != CRED_MAX));
    a_credit_invariant: assert property (@(posedge clk) disable iff (rst)
        (int'(cred) + int'(fifo_count) + $countones(vsr)) == DEPTH);

endmodule

// File: tb/tb_pipeline_flow_adapter.sv
// Scoreboard bench: two adapters (DEPTH 4 and DEPTH 2) each wrapping a 2-stage adder model.
module tb_pipeline_flow_adapter;

    localparam int W  = 32;
    localparam int NV = 8;
    localparam logic [W-1:0] VX [NV] = '{32'h0000_0003, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_5678,
                                        32'h8000_0000, 32'h0000_00FF, 32'hDEAD_0000, 32'h7FFF_FFFF};
    localparam logic [W-1:0] VY [NV] = '{32'h0000_0004, 32'h0000_0020, 32'h0000_0001, 32'h1111_1111,
                                        32'h8000_0000, 32'h0000_0001, 32'h0000_BEEF, 32'h0000_0001};
    localparam logic [W-1:0] VS [NV] = '{32'h0000_0007, 32'h0000_0030, 32'h0000_0000, 32'h2345_6789,
                                        32'h0000_0000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h8000_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_pipe_result, a_out_data, a_op_x, a_op_y, a_st1;
    int           a_idx = 0;
    int           a_accepts = 0;
    logic [W-1:0] a_exp_q [$];

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_pipe_result, b_out_data, b_op_x, b_op_y, b_st1;
    int           b_idx = 0;
    int           b_accepts = 0;
    logic [W-1:0] b_exp_q [$];

    pipeline_flow_adapter #(.WIDTH(W), .LATENCY(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .pipe_result(a_pipe_result), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data)
    );

    pipeline_flow_adapter #(.WIDTH(W), .LATENCY(2), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pipe_result(b_pipe_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data)
    );

    // Operands follow the vector table; the wrapped pipeline is an unreset 2-stage adder.
    assign a_op_x = VX[a_idx % NV];
    assign a_op_y = VY[a_idx % NV];
    assign b_op_x = VX[b_idx % NV];
    assign b_op_y = VY[b_idx % NV];

    always @(posedge clk) begin
        a_st1         <= a_op_x + a_op_y;
        a_pipe_result <= a_st1;
        b_st1         <= b_op_x + b_op_y;
        b_pipe_result <= b_st1;
        if (!rst && a_in_valid && a_in_ready) a_idx <= a_idx + 1;
        if (!rst && b_in_valid && b_in_ready) b_idx <= b_idx + 1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_in_valid && a_in_ready) begin
                a_exp_q.push_back(VS[a_idx % NV]);
                a_accepts++;
            end
            if (a_out_valid && a_out_ready) begin
                if (a_exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL a_spurious_out: got data %h, required no output", a_out_data);
                end else begin
                    check("a_order", a_out_data, a_exp_q.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) begin
                b_exp_q.push_back(VS[b_idx % NV]);
                b_accepts++;
            end
            if (b_out_valid && b_out_ready) begin
                if (b_exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL b_spurious_out: got data %h, required no output", b_out_data);
                end else begin
                    check("b_order", b_out_data, b_exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 30 && a_exp_q.size() != 0; i++) tick();
        check("a_drain_left", 32'(a_exp_q.size()), 32'd0);
        tick();
        check("a_drain_valid", 32'(a_out_valid), 32'd0);
    endtask

    task automatic drain_b();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 30 && b_exp_q.size() != 0; i++) tick();
        check("b_drain_left", 32'(b_exp_q.size()), 32'd0);
        tick();
        check("b_drain_valid", 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        int acc0;
        int ready_low;
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        #12;
        rst = 1'b0;
        tick();

        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", a_out_data, 32'd0);

        // Single item: issue in cycle t, visible in t+3, popped in t+3, gone in t+4.
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("single_t1_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("single_t2_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("single_t3_valid", 32'(a_out_valid), 32'd1);
        check("single_t3_data", a_out_data, 32'h0000_0007);
        a_out_ready = 1'b1;
        tick();
        check("single_t4_valid", 32'(a_out_valid), 32'd0);

        // Streaming: 20 back-to-back issues with no backpressure.
        acc0 = a_accepts;
        ready_low = 0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!a_in_ready) ready_low++;
            tick();
        end
        a_in_valid = 1'b0;
        check("stream_accepts", 32'(a_accepts - acc0), 32'd20);
        check("stream_ready_low", 32'(ready_low), 32'd0);
        drain_a();

        // Backpressure: exactly DEPTH accepts, head held stable, one credit per pop.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        acc0 = a_accepts;
        for (int i = 0; i < 8; i++) tick();
        check("bp_accepts", 32'(a_accepts - acc0), 32'd4);
        check("bp_in_ready", 32'(a_in_ready), 32'd0);
        check("bp_head_0", a_out_data, a_exp_q[0]);
        tick();
        check("bp_head_1", a_out_data, a_exp_q[0]);
        check("bp_valid_hold", 32'(a_out_valid), 32'd1);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("bp_credit_back", 32'(a_in_ready), 32'd1);
        acc0 = a_accepts;
        tick();
        check("bp_ready_drop", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("bp_one_more", 32'(a_accepts - acc0), 32'd1);

        // Near-full churn: captures and pops coincide while order is preserved.
        for (int i = 0; i < 24; i++) begin
            a_out_ready = i[0];
            tick();
        end
        drain_a();

        // Throughput limit with DEPTH=2: two accepts per four cycles.
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        acc0 = b_accepts;
        for (int i = 0; i < 16; i++) tick();
        b_in_valid = 1'b0;
        check("tput_accepts", 32'(b_accepts - acc0), 32'd8);
        drain_b();

        // Reset mid-flight: two results in the FIFO and two in the valid shift register.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        a_in_valid = 1'b0;
        check("mid_fifo_valid", 32'(a_out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
        check("mid_rst_out_data", a_out_data, 32'd0);
        a_exp_q.delete();
        tick();
        #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mid_after_valid", 32'(a_out_valid), 32'd0);
        check("mid_after_ready", 32'(a_in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
